mobo_mem: RTL and testbench

Motherboard-side memory target that sits directly downstream of the `cpu` block's bus interface. It consumes the CPU's `mobo_ctrl`, `addr_out` and `mobodat_out` outputs and returns `mobo_stat` and `mobodat_in`. It serves single-word reads and writes from an internal word-addressed RAM through a four-phase request/done handshake with a configurable access latency. It also flags out-of-range addresses.

---
 rtl/mobo_mem.sv | 100 ++++++++++
 tb/tb_mobo_mem.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mobo_mem.sv
// rtl/mobo_mem.sv - motherboard-side word RAM target behind the CPU bus interface
// Serves one read or write per four-phase req/done handshake after a fixed access latency.
module mobo_mem #(
  parameter int word_width = 32,
  parameter int mem_depth  = 256,
  parameter int latency    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] ctrl_in,
  output logic [word_width-1:0] stat_out,
  input  logic [word_width-1:0] addr_in,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out
);

  localparam int aw = (mem_depth > 1) ? $clog2(mem_depth) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [word_width-1:0] addr_l;
  logic [word_width-1:0] data_l;
  logic                  we_l;
  logic                  in_range;
  logic                  commit;
  logic [aw-1:0]         idx;
  logic [word_width-1:0] mem [0:mem_depth-1];
  logic                  req;
  logic [word_width-3:0] unused_ctrl;

  assign req         = ctrl_in[0];
  assign unused_ctrl = ctrl_in[word_width-1:2];
  assign in_range    = addr_l < word_width'(mem_depth);
  assign idx         = addr_l[aw-1:0];
  assign commit      = (state == ACCESS) && (cnt == 4'd0);

  function automatic logic [word_width-1:0] pack_stat(input logic busy, input logic done,
                                                      input logic err);
    logic [word_width-1:0] s;
    s    = '0;
    s[0] = busy;
    s[1] = done;
    s[2] = err;
    return s;
  endfunction

  // RAM has no reset; a reset before the commit edge leaves state IDLE so nothing is written.
  always_ff @(posedge clk) begin
    if (commit && we_l && in_range)
      mem[idx] <= data_l;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_l   <= '0;
      data_l   <= '0;
      we_l     <= 1'b0;
      stat_out <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_l   <= addr_in;
            data_l   <= data_in;
            we_l     <= ctrl_in[1];
            cnt      <= 4'(latency - 1);
            state    <= ACCESS;
            stat_out <= pack_stat(1'b1, 1'b0, 1'b0);
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            stat_out <= pack_stat(1'b1, 1'b1, !in_range);
            if (!we_l)
              data_out <= in_range ? mem[idx] : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!req) begin
            state    <= IDLE;
            stat_out <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          stat_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mobo_mem.sv
// tb/tb_mobo_mem.sv - directed bench for mobo_mem (latency 2 and latency 3 instances)
module tb_mobo_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl, addr, wdata, stat, dout;
  logic [31:0] ctrl3, addr3, wdata3, stat3, dout3;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mobo_mem #(.word_width(32), .mem_depth(256), .latency(2)) u_dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl), .stat_out(stat),
    .addr_in(addr), .data_in(wdata), .data_out(dout)
  );

  mobo_mem #(.word_width(32), .mem_depth(256), .latency(3)) u_dut3 (
    .clk(clk), .rst(rst), .ctrl_in(ctrl3), .stat_out(stat3),
    .addr_in(addr3), .data_in(wdata3), .data_out(dout3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit sel, input logic [31:0] c, input logic [31:0] a,
                     input logic [31:0] d);
    if (sel) begin
      ctrl3 = c; addr3 = a; wdata3 = d;
    end else begin
      ctrl = c; addr = a; wdata = d;
    end
  endtask

  function automatic logic [31:0] st(input bit sel);
    return sel ? stat3 : stat;
  endfunction

  // One complete transaction; busy/done timing is checked edge by edge from E0.
  task automatic xfer(input bit sel, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit exp_err, input bit chk_d, input logic [31:0] exp_d,
                      input string tag);
    int lat;
    lat = sel ? 3 : 2;
    drv(sel, {30'b0, we, 1'b1}, a, d);
    tick();
    check({tag, ":busy_e0"}, st(sel), 32'h1);
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i < lat)
        check({tag, ":access"}, st(sel), 32'h1);
      else
        check({tag, ":done"}, st(sel), exp_err ? 32'h7 : 32'h3);
    end
    if (chk_d)
      check({tag, ":rdata"}, sel ? dout3 : dout, exp_d);
    drv(sel, 32'h0, a, d);
    tick();
    check({tag, ":idle"}, st(sel), 32'h0);
  endtask

  initial begin
    drv(0, 32'h0, 32'h0, 32'h0);
    drv(1, 32'h0, 32'h0, 32'h0);
    #3;
    check("rst_stat", stat, 32'h0);
    check("rst_dout", dout, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "wr5");
    xfer(0, 1'b0, 32'd5, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, "rd5");

    xfer(0, 1'b1, 32'd0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, "wr0");
    xfer(0, 1'b0, 32'd256, 32'h0, 1'b1, 1'b1, 32'h0, "rd256");
    xfer(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, "wr1000");
    xfer(0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, "rd0");

    // req held after done: stays DONE, second access must not happen
    drv(0, 32'h3, 32'd9, 32'h77);
    tick(); tick(); tick();
    check("hold_done", stat, 32'h3);
    drv(0, 32'h3, 32'd9, 32'h99);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_stay", stat, 32'h3);
    end
    drv(0, 32'h0, 32'd9, 32'h99);
    tick();
    check("hold_idle", stat, 32'h0);
    xfer(0, 1'b0, 32'd9, 32'h0, 1'b0, 1'b1, 32'h77, "rd9");

    // req dropped during ACCESS: done lasts exactly one cycle
    drv(0, 32'h3, 32'd10, 32'h12);
    tick();
    check("drop_e0", stat, 32'h1);
    drv(0, 32'h0, 32'd10, 32'h12);
    tick();
    check("drop_access", stat, 32'h1);
    tick();
    check("drop_done", stat, 32'h3);
    tick();
    check("drop_idle", stat, 32'h0);
    xfer(0, 1'b0, 32'd10, 32'h0, 1'b0, 1'b1, 32'h12, "rd10");

    // inputs changed after acceptance are ignored
    xfer(0, 1'b1, 32'd4, 32'h44, 1'b0, 1'b0, 32'h0, "wr4");
    drv(0, 32'h3, 32'd3, 32'h11);
    tick();
    drv(0, 32'h3, 32'd4, 32'h22);
    tick(); tick();
    check("chg_done", stat, 32'h3);
    drv(0, 32'h0, 32'd4, 32'h22);
    tick();
    xfer(0, 1'b0, 32'd3, 32'h0, 1'b0, 1'b1, 32'h11, "rd3");
    xfer(0, 1'b0, 32'd4, 32'h0, 1'b0, 1'b1, 32'h44, "rd4");

    // asynchronous reset mid-access on the latency-3 instance
    xfer(1, 1'b1, 32'd7, 32'h33, 1'b0, 1'b0, 32'h0, "l3_wr7");
    drv(1, 32'h3, 32'd7, 32'h55);
    drv(0, 32'h1, 32'd0, 32'h0);
    tick();
    check("l3_busy", stat3, 32'h1);
    check("l2_busy", stat, 32'h1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_stat3", stat3, 32'h0);
    check("arst_stat", stat, 32'h0);
    check("arst_dout", dout, 32'h0);
    tick(); tick();
    check("rst_hold_stat", stat, 32'h0);
    check("rst_hold_stat3", stat3, 32'h0);
    drv(0, 32'h0, 32'd0, 32'h0);
    drv(1, 32'h0, 32'd7, 32'h55);
    rst = 1'b0;
    tick();
    xfer(1, 1'b0, 32'd7, 32'h0, 1'b0, 1'b1, 32'h33, "l3_rd7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
